// File: rtl/bitcount_arb_pkg.sv
// Shared types and helpers for the bitcount round-robin arbiter.
// Optional watchdog macro used by the top: BITCOUNT_ARB_TIMEOUT_EN.
package bitcount_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int MAX_REQ = 8;

  function automatic int res_width(input int width);
    return $clog2(width + 1);
  endfunction

  // First set bit at or after ptr, wrapping modulo n; 0 when req is empty.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    int win;
    bit found;
    logic [2:0] idx;
    win = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = 3'((ptr + i) % n);
      if (i < n && !found && req[idx]) begin
        win = int'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/bitcount_arbiter_rr_picker.sv
// Combinational round-robin picker: winner index and valid from req and pointer.
module rr_picker
  import bitcount_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = req;
    winner = IDX_W'(rr_pick(req_ext, int'(ptr), NUM_REQ));
    valid = |req;
  end

endmodule

// File: rtl/bitcount_arbiter.sv
// Round-robin scheduler sharing one iterative bit-count unit among NUM_REQ clients.
// Define BITCOUNT_ARB_TIMEOUT_EN to add a BUSY watchdog that reports resp_err.
module bitcount_arbiter
  import bitcount_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int RES_W = res_width(WIDTH),
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [RES_W-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     unit_go,
  output logic [WIDTH-1:0]         unit_in,
  input  logic                     unit_done,
  input  logic [RES_W-1:0]         unit_out
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("bitcount_arbiter: unsupported parameter combination");
  end

  state_t state, state_next;

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   winner_q;
  logic [IDX_W-1:0]   pick;
  logic               pick_valid;
  logic [WIDTH-1:0]   operand_q;
  logic [WIDTH-1:0]   sel_data;
  logic [RES_W-1:0]   result_q;
  logic               first_busy;
  logic               done_ok;
  logic               timed_out;
  logic [NUM_REQ-1:0] winner_oh;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  // The first BUSY cycle may still show done from the previous job.
  assign done_ok = (state == BUSY) && !first_busy && unit_done;

`ifdef BITCOUNT_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog;
  logic            err_q;

  assign timed_out = (state == BUSY) && !done_ok && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == LAUNCH) begin
        wdog  <= '0;
        err_q <= 1'b0;
      end else if (state == BUSY) begin
        wdog <= wdog + 1'b1;
      end
      if (timed_out) err_q <= 1'b1;
    end
  end

  assign resp_err = (state == RESP) && err_q;
`else
  assign timed_out = 1'b0;
  assign resp_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = LAUNCH;
      LAUNCH:  state_next = BUSY;
      BUSY:    if (done_ok || timed_out) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = state_t'('x);
    endcase
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      winner_q   <= '0;
      operand_q  <= '0;
      result_q   <= '0;
      first_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            winner_q  <= pick;
            operand_q <= sel_data;
          end
        end
        LAUNCH: first_busy <= 1'b1;
        BUSY: begin
          first_busy <= 1'b0;
          if (done_ok)        result_q <= unit_out;
          else if (timed_out) result_q <= '0;
        end
        RESP: ptr <= (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    winner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_q == IDX_W'(i)) winner_oh[i] = 1'b1;
    end
  end

  assign grant      = (state != IDLE) ? winner_oh : '0;
  assign resp_valid = (state == RESP) ? winner_oh : '0;
  assign resp_data  = (state == RESP) ? result_q : '0;
  assign unit_go    = (state == LAUNCH);
  assign unit_in    = operand_q;

endmodule

// File: tb/tb_bitcount_arbiter.sv
// Scoreboard bench for bitcount_arbiter with a behavioural bit-count unit.
// Define BITCOUNT_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_bitcount_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int RES_W   = 5;
`ifdef BITCOUNT_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 64;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [RES_W-1:0]         resp_data;
  logic                     resp_err;
  logic                     unit_go;
  logic [WIDTH-1:0]         unit_in;
  logic                     unit_done;
  logic [RES_W-1:0]         unit_out;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int go_count = 0;
  int last_go_cycle = 0;
  int last_resp_cycle = 0;

  typedef struct {
    int               idx;
    logic [RES_W-1:0] data;
    logic             err;
  } exp_t;

  exp_t               exp_q[$];
  logic [NUM_REQ-1:0] grant_q[$];

  bit               stale_mode = 1'b0;
  bit               stuck_mode = 1'b0;
  int               unit_lat = 3;
  int               unit_cnt = 0;
  bit               unit_busy = 1'b0;
  logic [WIDTH-1:0] unit_op = '0;

  bitcount_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .unit_go    (unit_go),
    .unit_in    (unit_in),
    .unit_done  (unit_done),
    .unit_out   (unit_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Bit-count unit: done stays high after a job until the next go (or one cycle longer in stale mode).
  always @(posedge clk) begin
    if (rst) begin
      unit_done <= 1'b0;
      unit_out  <= '0;
      unit_busy <= 1'b0;
      unit_cnt  <= 0;
    end else if (unit_go) begin
      unit_op   <= unit_in;
      unit_cnt  <= unit_lat;
      unit_busy <= !stuck_mode;
      if (!stale_mode) unit_done <= 1'b0;
    end else if (unit_busy) begin
      unit_done <= 1'b0;
      if (unit_cnt == 1) begin
        unit_done <= 1'b1;
        unit_out  <= RES_W'($countones(unit_op));
        unit_busy <= 1'b0;
      end
      unit_cnt <= unit_cnt - 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0h, expected nothing", name, act);
  endtask

  // Monitor: compares grant at each launch and every response against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (unit_go) begin
        go_count++;
        last_go_cycle = cycle;
        if (grant_q.size() == 0) reportUnexpected("grant_unexpected", grant);
        else checkOutput("grant", grant, grant_q.pop_front());
      end
      if (resp_valid != '0) begin
        if (exp_q.size() == 0) begin
          reportUnexpected("resp_unexpected", resp_valid);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("resp_valid", resp_valid, 4'(1) << e.idx);
          checkOutput("resp_data", resp_data, e.data);
          checkOutput("resp_err", resp_err, e.err);
        end
      end
    end
  end

  task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] data,
                               input logic [RES_W-1:0] exp_data, input logic exp_err);
    exp_t e;
    e.idx  = idx;
    e.data = exp_data;
    e.err  = exp_err;
    req_data[idx*WIDTH +: WIDTH] = data;
    req[idx] = 1'b1;
    exp_q.push_back(e);
    grant_q.push_back(4'(1) << idx);
  endtask

  // Waits for requester idx to be answered, dropping each requester's req as it is served.
  task automatic waitResp(input int idx, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (resp_valid[idx]) begin
        seen = 1'b1;
        last_resp_cycle = cycle;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (resp_valid[i]) req[i] = 1'b0;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL wait_resp%0d: no response within %0d cycles", idx, budget);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_grant"}, grant, 0);
    checkOutput({tag, "_resp_valid"}, resp_valid, 0);
    checkOutput({tag, "_resp_data"}, resp_data, 0);
    checkOutput({tag, "_resp_err"}, resp_err, 0);
    checkOutput({tag, "_unit_go"}, unit_go, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    bit go_seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("por");
    rst = 1'b0;

    $display("[TB] single request");
    @(negedge clk);
    applyStimulus(2, 16'h00F3, 5'd6, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("t1_grant_next_cycle", grant, 4'b0100);
    waitResp(2, 40);
    checkOutput("t1_go_count", go_count, 1);

    $display("[TB] round robin");
    doReset();
    applyStimulus(0, 16'h0001, 5'd1, 1'b0);
    applyStimulus(1, 16'h0003, 5'd2, 1'b0);
    applyStimulus(2, 16'h0007, 5'd3, 1'b0);
    applyStimulus(3, 16'hFFFF, 5'd16, 1'b0);
    waitResp(0, 40);
    applyStimulus(0, 16'h8421, 5'd4, 1'b0);
    waitResp(3, 120);
    waitResp(0, 40);

    $display("[TB] wrap-around");
    applyStimulus(2, 16'h00FF, 5'd8, 1'b0);
    waitResp(2, 40);
    applyStimulus(3, 16'h1111, 5'd4, 1'b0);
    applyStimulus(0, 16'hAAAA, 5'd8, 1'b0);
    waitResp(0, 80);

    $display("[TB] stale done");
    stale_mode = 1'b1;
    applyStimulus(1, 16'h0005, 5'd2, 1'b0);
    waitResp(1, 40);
    stale_mode = 1'b0;

    $display("[TB] reset mid-busy");
    req_data[2*WIDTH +: WIDTH] = 16'h1234;
    req[2] = 1'b1;
    grant_q.push_back(4'b0100);
    go_seen = 1'b0;
    for (int n = 0; n < 10 && !go_seen; n++) begin
      @(negedge clk);
      if (unit_go) go_seen = 1'b1;
    end
    checkOutput("t5_launch_seen", go_seen, 1);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    checkIdleOutputs("t5_abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

`ifdef BITCOUNT_ARB_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    stuck_mode = 1'b1;
    applyStimulus(1, 16'hFFF0, 5'd0, 1'b1);
    applyStimulus(3, 16'h0300, 5'd2, 1'b0);
    waitResp(1, 40);
    stuck_mode = 1'b0;
    checkOutput("t6_timeout_latency", last_resp_cycle - last_go_cycle, 9);
    waitResp(3, 40);
`endif

    repeat (3) @(negedge clk);
    checkOutput("exp_queue_empty", exp_q.size(), 0);
    checkOutput("grant_queue_empty", grant_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
